// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and sizing helpers for the PWM RGB driver
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } pwm_state_t;

   // Width of a counter that must hold 0..interval-1; never narrower than one bit.
   function automatic int cnt_width(input int interval);
      return (interval > 1) ? $clog2(interval) : 1;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: duty clamp, counter compare, registered pin drive
module pwm_channel #(
   parameter int PWM_INTERVAL = 1000,
   parameter int DUTY_W       = $clog2(PWM_INTERVAL),
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   input  logic [DUTY_W:0] cnt,
   input  logic [DUTY_W-1:0] duty,
   output logic            pwm
);

   localparam logic [DUTY_W:0] FULL = (DUTY_W + 1)'(PWM_INTERVAL);

   logic [DUTY_W:0] duty_ext;
   logic [DUTY_W:0] duty_clamped;
   logic            on;

   // Duties beyond the period saturate to "on all period" instead of wrapping.
   assign duty_ext     = {1'b0, duty};
   assign duty_clamped = (duty_ext >= FULL) ? FULL : duty_ext;
   assign on           = (cnt < duty_clamped);

   always_ff @(posedge clk) begin
      if (reset) begin
         pwm <= ACTIVE_LOW;
      end else if (run) begin
         pwm <= on ^ ACTIVE_LOW;
      end else begin
         pwm <= ACTIVE_LOW;
      end
   end

endmodule

// File: rtl/pwm_rgb_driver.sv
// rtl/pwm_rgb_driver.sv - multi-channel PWM with shadowed duty updates and clean start/stop
module pwm_rgb_driver
   import pwm_pkg::*;
#(
   parameter int PWM_INTERVAL = 1000,
   parameter int N_CH         = 3,
   parameter bit ACTIVE_LOW   = 1'b1,
   parameter int DUTY_W       = $clog2(PWM_INTERVAL)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic [N_CH*DUTY_W-1:0]   duty_in,
   input  logic                     duty_valid,
   output logic                     duty_ready,
   output logic [N_CH-1:0]          pwm_out,
   output logic                     period_start
);

   localparam int              CNT_W   = cnt_width(PWM_INTERVAL);
   localparam int              CMP_W   = DUTY_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PWM_INTERVAL - 1);

   pwm_state_t               state, state_nxt;
   logic [CNT_W-1:0]         cnt;
   logic [CMP_W-1:0]         cnt_ext;
   logic [N_CH*DUTY_W-1:0]   shadow;
   logic [N_CH*DUTY_W-1:0]   active;
   logic                     pending;
   logic                     counting;
   logic                     wrap;
   logic                     commit;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (!en) state_nxt = DRAIN;
         DRAIN: begin
            if (en) state_nxt = RUN;
            else if (cnt == CNT_MAX) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Commit happens only when the counter lands on 0 and the next period is a RUN period.
   always_comb begin
      counting = (state != IDLE);
      wrap     = counting && (cnt == CNT_MAX);
      commit   = (state_nxt == RUN) && ((state == IDLE) || wrap);
   end

   always_ff @(posedge clk) begin
      if (reset || !counting || wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // A transfer needs pending clear and a commit needs it set, so the two never collide.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
      end else if (duty_valid && !pending) begin
         shadow  <= duty_in;
         pending <= 1'b1;
      end else if (commit && pending) begin
         active  <= shadow;
         pending <= 1'b0;
      end
   end

   assign duty_ready = !pending;

   always_ff @(posedge clk) begin
      if (reset) begin
         period_start <= 1'b0;
      end else begin
         period_start <= counting && (cnt == '0);
      end
   end

   assign cnt_ext = CMP_W'(cnt);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      pwm_channel #(
         .PWM_INTERVAL (PWM_INTERVAL),
         .DUTY_W       (DUTY_W),
         .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .run   (counting),
         .cnt   (cnt_ext),
         .duty  (active[i*DUTY_W +: DUTY_W]),
         .pwm   (pwm_out[i])
      );
   end

endmodule

// File: tb/tb_pwm_rgb_driver.sv
// tb/tb_pwm_rgb_driver.sv - randomized and directed checks of pwm_rgb_driver against a behavioural model
module tb_pwm_rgb_driver;

   localparam int P  = 10;
   localparam int NC = 3;
   localparam int DW = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              en = 1'b0;
   logic [NC*DW-1:0]  duty_in = '0;
   logic              duty_valid = 1'b0;
   logic              duty_ready;
   logic [NC-1:0]     pwm_out;
   logic              period_start;

   always #5 clk = ~clk;

   pwm_rgb_driver #(
      .PWM_INTERVAL (P),
      .N_CH         (NC),
      .ACTIVE_LOW   (1'b1),
      .DUTY_W       (DW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .duty_in      (duty_in),
      .duty_valid   (duty_valid),
      .duty_ready   (duty_ready),
      .pwm_out      (pwm_out),
      .period_start (period_start)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Model: mode 0 = stopped, 1 = running, 2 = finishing the current period.
   int          m_mode = 0;
   int          m_pos = 0;
   int          m_active[NC];
   int          m_shadow[NC];
   bit          m_pending = 1'b0;
   logic [NC-1:0] m_pwm = '1;
   bit          m_ps = 1'b0;

   task automatic cycle();
      bit boundary;
      bit xfer;
      int on_len;
      if (reset) begin
         m_mode = 0;
         m_pos = 0;
         m_pending = 1'b0;
         m_pwm = '1;
         m_ps = 1'b0;
         for (int c = 0; c < NC; c++) begin
            m_active[c] = 0;
            m_shadow[c] = 0;
         end
      end else begin
         xfer = duty_valid && !m_pending;
         m_ps = (m_mode != 0) && (m_pos == 0);
         for (int c = 0; c < NC; c++) begin
            on_len = (m_active[c] < P) ? m_active[c] : P;
            m_pwm[c] = (m_mode != 0) ? !(m_pos < on_len) : 1'b1;
         end
         boundary = 1'b0;
         case (m_mode)
            0: if (en) begin
               m_mode = 1;
               m_pos = 0;
               boundary = 1'b1;
            end
            1: begin
               m_pos = (m_pos + 1) % P;
               if (!en) m_mode = 2;
               else boundary = (m_pos == 0);
            end
            default: begin
               m_pos = (m_pos + 1) % P;
               if (en) begin
                  m_mode = 1;
                  boundary = (m_pos == 0);
               end else if (m_pos == 0) begin
                  m_mode = 0;
               end
            end
         endcase
         if (xfer) begin
            for (int c = 0; c < NC; c++) m_shadow[c] = int'(duty_in[c*DW +: DW]);
            m_pending = 1'b1;
         end else if (boundary && m_pending) begin
            for (int c = 0; c < NC; c++) m_active[c] = m_shadow[c];
            m_pending = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      check("pwm_out", 32'(pwm_out), 32'(m_pwm));
      check("period_start", 32'(period_start), 32'(m_ps));
      check("duty_ready", 32'(duty_ready), 32'(!m_pending));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_pos(input int p);
      for (int i = 0; i < 3 * P; i++) begin
         if (m_mode != 0 && m_pos == p) break;
         cycle();
      end
      check("wait_pos", 32'(m_mode != 0 && m_pos == p), 32'd1);
   endtask

   task automatic load(input logic [NC*DW-1:0] d);
      duty_in = d;
      duty_valid = 1'b1;
      cycle();
      duty_valid = 1'b0;
   endtask

   initial begin
      for (int c = 0; c < NC; c++) begin
         m_active[c] = 0;
         m_shadow[c] = 0;
      end
      reset = 1'b1;
      run(2);
      check("rst_pwm", 32'(pwm_out), 32'h7);
      check("rst_ready", 32'(duty_ready), 32'd1);
      check("rst_ps", 32'(period_start), 32'd0);
      reset = 1'b0;
      run(50);

      // Mixed duties including zero and exactly-full.
      load({4'd10, 4'd0, 4'd3});
      en = 1'b1;
      run(35);

      // Update mid-period, then a second request while the shadow is still full.
      wait_pos(4);
      load({4'd10, 4'd0, 4'd7});
      duty_in = {4'd9, 4'd9, 4'd9};
      duty_valid = 1'b1;
      cycle();
      duty_valid = 1'b0;
      run(25);

      // Stop mid-period, then stop again and resume while draining.
      wait_pos(4);
      en = 1'b0;
      run(15);
      en = 1'b1;
      run(3);
      wait_pos(4);
      en = 1'b0;
      run(2);
      en = 1'b1;
      run(20);

      // Over-range duty, then reset with an update still pending.
      load({4'd0, 4'd15, 4'd3});
      run(12);
      wait_pos(2);
      load({4'd5, 4'd5, 4'd5});
      wait_pos(5);
      reset = 1'b1;
      cycle();
      check("rst_mid_pwm", 32'(pwm_out), 32'h7);
      check("rst_mid_ready", 32'(duty_ready), 32'd1);
      reset = 1'b0;
      en = 1'b0;
      run(3);

      // Zero duty loaded while stopped commits on entry.
      load({4'd0, 4'd0, 4'd0});
      run(2);
      en = 1'b1;
      run(12);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) en = ~en;
         duty_valid = $urandom_range(0, 1) == 1;
         duty_in = NC*DW'($urandom);
         reset = ($urandom_range(0, 299) == 0);
         cycle();
      end
      reset = 1'b0;
      duty_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
